// File: rtl/ulpi_pkg.sv
// rtl/ulpi_pkg.sv - shared types and constants for the ULPI link (ADDR width set by ULPI_LINK_EXTREG_EN)
package ulpi_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TXCMD,
    EXTADDR,
    WDATA,
    WSTP,
    RTURN,
    RDATA,
    RXTURN,
    RX
  } ulpi_state_e;

`ifdef ULPI_LINK_EXTREG_EN
  localparam int ADDR_W = 8;
`else
  localparam int ADDR_W = 6;
`endif

  // TX CMD prefixes for register access
  localparam logic [1:0] CMD_REG_WRITE = 2'b10;
  localparam logic [1:0] CMD_REG_READ  = 2'b11;
  localparam logic [5:0] CMD_EXT_ADDR  = 6'h2F;

  // RX CMD field positions
  localparam int         RXCMD_LINESTATE_LSB = 0;
  localparam int         RXCMD_LINESTATE_MSB = 1;
  localparam int         RXCMD_RXACTIVE_LSB  = 4;
  localparam int         RXCMD_RXACTIVE_MSB  = 5;
  localparam logic [1:0] RXCMD_RXACTIVE_CODE = 2'b01;

  // Build the TX CMD byte for an immediate or extended register access
  function automatic logic [7:0] txcmd_byte(input logic is_read, input logic is_ext,
                                            input logic [5:0] addr6);
    return {(is_read ? CMD_REG_READ : CMD_REG_WRITE), (is_ext ? CMD_EXT_ADDR : addr6)};
  endfunction

endpackage

// File: rtl/ulpi_rx_fifo.sv
// rtl/ulpi_rx_fifo.sv - RX byte FIFO with registered head byte and drop-on-full
module ulpi_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             dropped
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_n;
  logic [PW:0]      count;
  logic [PW:0]      count_n;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (PW + 1)'(DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && head_valid;
  assign dropped  = push && full;
  assign rd_ptr_n = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_n = count;
    if (push_ok && !pop_ok) begin
      count_n = count + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_n = count - 1'b1;
    end
  end

  // Storage write; contents need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
    end
  end

  // Registered head: bypass the incoming byte when it lands at the new read slot
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      head_valid <= (count_n != '0);
      head_data  <= (push_ok && (wr_ptr == rd_ptr_n)) ? push_data : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/ulpi_link.sv
// rtl/ulpi_link.sv - ULPI link register access FSM and RX path (ULPI_LINK_EXTREG_EN enables extended addresses)
module ulpi_link
  import ulpi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int NXT_TIMEOUT = 255
) (
  input  logic              clk_ext,
  input  logic              rst,
  input  logic              WD,
  input  logic              RD,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        DATA_IN,
  output logic [7:0]        DATA_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [7:0]        RX_DATA,
  output logic              RX_VALID,
  input  logic              RX_READY,
  output logic [7:0]        RX_CMD,
  output logic              RX_ACTIVE,
  output logic              OVF,
  input  logic              DIR,
  input  logic              NXT,
  output logic              STP,
  inout  wire  [7:0]        ULPI_DATA
);

  ulpi_state_e       state;
  ulpi_state_e       state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              rd_q;
  logic              ext_q;
  logic              rd_got;
  logic [15:0]       nxt_cnt;
  logic              ext_req;
  logic              timeout;
  logic              drive_en;
  logic [7:0]        tx_byte;
  logic              done_set;
  logic              err_set;
  logic              stp_set;
  logic              latch_req;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              capture_rd;
  logic              rx_push;
  logic              rx_cmd_load;
  logic              fifo_dropped;

`ifdef ULPI_LINK_EXTREG_EN
  assign ext_req = (ADDR >= {2'b00, CMD_EXT_ADDR});
`else
  assign ext_req = 1'b0;
`endif

  assign timeout     = (nxt_cnt == 16'(NXT_TIMEOUT - 1));
  assign ULPI_DATA   = drive_en ? tx_byte : 8'bz;
  assign BUSY        = (state == TXCMD) || (state == EXTADDR) || (state == WDATA) ||
                       (state == WSTP) || (state == RTURN) || (state == RDATA);
  assign rx_push     = (state == RX) && DIR && NXT;
  assign rx_cmd_load = (state == RX) && DIR && !NXT;
  assign RX_ACTIVE   = (RX_CMD[RXCMD_RXACTIVE_MSB:RXCMD_RXACTIVE_LSB] == RXCMD_RXACTIVE_CODE);

  // State register
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, bus drive and event strobes; the bus is released combinationally on DIR
  always_comb begin
    state_n    = state;
    drive_en   = 1'b0;
    tx_byte    = 8'h00;
    done_set   = 1'b0;
    err_set    = 1'b0;
    stp_set    = 1'b0;
    latch_req  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    capture_rd = 1'b0;
    case (state)
      IDLE: begin
        drive_en = !DIR;
        if (DIR) begin
          state_n = RXTURN;
        end else if (WD || RD) begin
          latch_req = 1'b1;
          state_n   = TXCMD;
        end
      end
      TXCMD, EXTADDR, WDATA: begin
        drive_en = !DIR;
        if (state == TXCMD) begin
          tx_byte = txcmd_byte(rd_q, ext_q, addr_q[5:0]);
        end else if (state == EXTADDR) begin
          tx_byte = 8'(addr_q);
        end else begin
          tx_byte = data_q;
        end
        if (DIR) begin
          err_set = 1'b1;
          state_n = RXTURN;
        end else if (NXT) begin
          cnt_clr = 1'b1;
          if (state == WDATA) begin
            stp_set  = 1'b1;
            done_set = 1'b1;
            state_n  = WSTP;
          end else if (state == TXCMD && ext_q) begin
            state_n = EXTADDR;
          end else begin
            state_n = rd_q ? RTURN : WDATA;
          end
        end else if (timeout) begin
          err_set = 1'b1;
          stp_set = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WSTP: begin
        drive_en = !DIR;
        state_n  = IDLE;
      end
      RTURN: begin
        if (DIR) begin
          state_n = RDATA;
        end
      end
      RDATA: begin
        if (DIR) begin
          capture_rd = !rd_got;
        end else begin
          // This cycle is the turnaround back to the link
          done_set = rd_got;
          err_set  = !rd_got;
          state_n  = IDLE;
        end
      end
      RXTURN: begin
        state_n = DIR ? RX : IDLE;
      end
      RX: begin
        if (!DIR) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request latch, NXT wait counter and read-data capture
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      addr_q   <= '0;
      data_q   <= 8'h00;
      rd_q     <= 1'b0;
      ext_q    <= 1'b0;
      rd_got   <= 1'b0;
      nxt_cnt  <= '0;
      DATA_OUT <= 8'h00;
    end else begin
      if (latch_req) begin
        addr_q <= ADDR;
        data_q <= DATA_IN;
        rd_q   <= !WD;
        ext_q  <= ext_req;
        rd_got <= 1'b0;
      end else if (capture_rd) begin
        rd_got <= 1'b1;
      end
      if (latch_req || cnt_clr) begin
        nxt_cnt <= '0;
      end else if (cnt_inc) begin
        nxt_cnt <= nxt_cnt + 1'b1;
      end
      if (capture_rd) begin
        DATA_OUT <= ULPI_DATA;
      end
    end
  end

  // Registered one-cycle strobes, RX CMD capture and sticky overflow
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      STP    <= 1'b0;
      RX_CMD <= 8'h00;
      OVF    <= 1'b0;
    end else begin
      DONE <= done_set;
      ERR  <= err_set;
      STP  <= stp_set;
      if (rx_cmd_load) begin
        RX_CMD <= ULPI_DATA;
      end
      if (fifo_dropped) begin
        OVF <= 1'b1;
      end
    end
  end

  ulpi_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_rx_fifo (
    .clk       (clk_ext),
    .rst       (rst),
    .push      (rx_push),
    .push_data (ULPI_DATA),
    .pop       (RX_READY),
    .head_data (RX_DATA),
    .head_valid(RX_VALID),
    .dropped   (fifo_dropped)
  );

endmodule

// File: doc/ulpi_link.md
ULPI_LINK -- requirements
Module: ulpi_link

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, RX data FIFO depth in bytes; power of two, >= 2.
REQ-002 Parameter NXT_TIMEOUT, default 255, max cycles waiting for NXT before abort; 1..65535.
REQ-003 clk_ext  input  1  ULPI 60 MHz clock from PHY; sole clock, all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 WD  input  1  register-write request, sampled in IDLE only.
REQ-006 RD  input  1  register-read request, sampled in IDLE only; WD wins if both high.
REQ-007 ADDR  input  6 (8 with ULPI_LINK_EXTREG_EN)  PHY register address.
REQ-008 DATA_IN  input  8  write data.
REQ-009 DATA_OUT  output  8  last register read result.
REQ-010 BUSY  output  1  high while a register access is in progress.
REQ-011 DONE  output  1  one-cycle pulse on successful access completion.
REQ-012 ERR  output  1  one-cycle pulse on aborted access (DIR preempt or NXT timeout).
REQ-013 RX_DATA  output  8  FIFO head byte; RX_VALID output 1 head valid; RX_READY input 1 pop when RX_VALID.
REQ-014 RX_CMD  output  8  last RX CMD byte; RX_ACTIVE output 1 = RX_CMD[5:4]==2'b01.
REQ-015 OVF  output  1  sticky: RX byte dropped because FIFO full.
REQ-016 DIR, NXT  input  1  ULPI bus direction / next; STP output 1 ULPI stop.
REQ-017 ULPI_DATA  inout  8  driven by link only when DIR low and state drives; else high-Z.

Function
REQ-018 States: IDLE, TXCMD, EXTADDR, WDATA, WSTP, RTURN, RDATA, RXTURN, RX.
REQ-019 IDLE, DIR low: link drives 8'h00; WD/RD latches ADDR, DATA_IN, goes TXCMD, BUSY high next cycle.
REQ-020 TXCMD drives 2'b10,ADDR (write) or 2'b11,ADDR (read); holds until NXT high.
REQ-021 Write: cycle after NXT drives DATA_IN in WDATA until NXT high; then WSTP: STP high one cycle, data 8'h00, DONE pulse, IDLE.
REQ-022 Read: after NXT in TXCMD, RTURN waits for DIR high (turnaround, no sample); RDATA samples ULPI_DATA into DATA_OUT the next cycle; DONE pulse when DIR falls, one turnaround cycle, IDLE.
REQ-023 DIR rising in TXCMD/EXTADDR/WDATA before final NXT: release bus same cycle, ERR pulse, request dropped, go RXTURN.
REQ-024 NXT counter counts each wait cycle; reaching NXT_TIMEOUT: STP high one cycle, ERR pulse, IDLE.
REQ-025 DIR rising in IDLE: RXTURN one cycle, no sample; then RX.
REQ-026 RX, DIR high: NXT low -> byte to RX_CMD; NXT high -> byte pushed to FIFO.
REQ-027 DIR falling in RX: one turnaround cycle, IDLE; pending WD/RD ignored while not IDLE.
REQ-028 FIFO: push and pop in same cycle allowed when not empty; full push drops byte, sets OVF; pop when empty ignored.
REQ-029 RX_DATA/RX_VALID registered; first byte visible one cycle after push; pointers wrap modulo FIFO_DEPTH.
REQ-030 STP low at all times except WSTP and timeout abort.

Reset
REQ-031 rst high: state IDLE, FIFO empty, DATA_OUT=0, RX_CMD=0, OVF=0, BUSY/DONE/ERR/STP/RX_VALID=0, bus released.
REQ-032 rst mid-access aborts with no DONE/ERR; DIR high at rst release enters RXTURN next cycle.

Configuration
REQ-033 ULPI_LINK_EXTREG_EN defined: ADDR 8 bits; ADDR>=8'h2F uses TXCMD 8'hAF/8'hEF, then EXTADDR drives ADDR until NXT, then data phase as REQ-021/022.
REQ-034 ULPI_LINK_EXTREG_EN undefined: ADDR 6 bits, EXTADDR unreachable, immediate commands only.

Structure
REQ-035 Package ulpi_pkg: state enum, TXCMD prefixes (write 2'b10, read 2'b11, ext 6'h2F), RX CMD field positions.
REQ-036 Sub-module ulpi_rx_fifo (parametrised FIFO_DEPTH, width 8) holds RX buffering; FSM stays in ulpi_link.

Verification
REQ-037 WD, ADDR=6'h04, DATA_IN=8'h45, NXT after 2 cycles each phase -> bus 8'h84 then 8'h45, STP one cycle, DONE once.
REQ-038 RD ADDR=6'h00, PHY turnaround then 8'h24 -> bus 8'hC0, DATA_OUT=8'h24, DONE, ERR low.
REQ-039 DIR high during TXCMD -> ERR pulse, bus high-Z same cycle, no DONE, RX_CMD captures next NXT-low byte.
REQ-040 RX burst of FIFO_DEPTH+1 bytes, RX_READY low -> first FIFO_DEPTH bytes kept in order, OVF=1.
REQ-041 NXT never asserted after WD -> ERR at cycle NXT_TIMEOUT, STP one cycle, IDLE.
REQ-042 With ULPI_LINK_EXTREG_EN, WD ADDR=8'h80, DATA_IN=8'h11 -> bus 8'hAF, 8'h80, 8'h11, STP, DONE.
